// File: rtl/pc_sequencer.sv
// pc_sequencer: issues program counter values downstream over a valid/ready
// handshake and uses the shared external adder to form the next PC
// (PC + STEP, or PC + branch_offset when a branch accompanies the handshake).
module pc_sequencer #(
    parameter int WIDTH    = 6,
    parameter int STEP     = 1,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             pc_ready,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             busy,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] add_a_reg, add_a_next;
    logic [WIDTH-1:0] add_b_reg, add_b_next;
    logic             wrap_reg, wrap_next;
    logic             halt_pending_reg, halt_pending_next;
    logic             handshake;

    // pc_valid and busy are pure decodes of the registered state, so they
    // are glitch-free and change only on clock edges.
    assign pc_valid  = (state_reg == ISSUE);
    assign busy      = (state_reg != IDLE);
    assign handshake = (state_reg == ISSUE) && pc_ready;
    assign pc_out    = pc_reg;
    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign wrap      = wrap_reg;

    // State and datapath registers; reset may land in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            pc_reg           <= RESET_PC_W;
            add_a_reg        <= '0;
            add_b_reg        <= '0;
            wrap_reg         <= 1'b0;
            halt_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            add_a_reg        <= add_a_next;
            add_b_reg        <= add_b_next;
            wrap_reg         <= wrap_next;
            halt_pending_reg <= halt_pending_next;
        end
    end

    // Next-state and register-update logic; everything holds by default and
    // wrap is a single-cycle pulse, so it defaults low.
    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        add_a_next        = add_a_reg;
        add_b_next        = add_b_reg;
        wrap_next         = 1'b0;
        halt_pending_next = halt_pending_reg;
        case (state_reg)
            IDLE: begin
                // halt has priority over start
                if (start && !halt) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    // Operands are captured only here; branch inputs are
                    // ignored on every other cycle.
                    add_a_next        = pc_reg;
                    add_b_next        = branch_valid ? branch_offset : STEP_W;
                    halt_pending_next = halt;
                    state_next        = UPDATE;
                end else if (halt) begin
                    state_next = IDLE;
                end
            end
            UPDATE: begin
                // A modulo sum smaller than operand A means the carry was
                // dropped, i.e. the PC wrapped.
                pc_next   = add_sum;
                wrap_next = (add_sum < add_a_reg);
                if (halt || halt_pending_reg) begin
                    halt_pending_next = 1'b0;
                    state_next        = IDLE;
                end else begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with a behavioural external adder.
module tb_pc_sequencer;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             halt;
    logic             branch_valid;
    logic [WIDTH-1:0] branch_offset;
    logic             pc_ready;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] pc_out;
    logic             pc_valid;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             busy;
    logic             wrap;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(.WIDTH(WIDTH), .STEP(1), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt         (halt),
        .branch_valid (branch_valid),
        .branch_offset(branch_offset),
        .pc_ready     (pc_ready),
        .add_sum      (add_sum),
        .pc_out       (pc_out),
        .pc_valid     (pc_valid),
        .add_a        (add_a),
        .add_b        (add_b),
        .busy         (busy),
        .wrap         (wrap)
    );

    // External combinational adder; the 6-bit result drops the carry.
    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full observable status of the block in one call.
    task automatic check_status(input string tag, input int pc, input int v,
                                input int b, input int w);
        check_eq({tag, ".pc_out"}, int'(pc_out), pc);
        check_eq({tag, ".pc_valid"}, int'(pc_valid), v);
        check_eq({tag, ".busy"}, int'(busy), b);
        check_eq({tag, ".wrap"}, int'(wrap), w);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; branch_valid = 1'b0;
        branch_offset = '0; pc_ready = 1'b0;
        step(); step();
        check_status("reset", 0, 0, 0, 0);
        check_eq("reset.add_a", int'(add_a), 0);
        check_eq("reset.add_b", int'(add_b), 0);

        // Free run with ready tied high: one accepted PC every 2 cycles.
        rst = 1'b0; start = 1'b1; pc_ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            check_status($sformatf("run%0d.issue", k), k, 1, 1, 0);
            step();
            check_status($sformatf("run%0d.update", k), k, 0, 1, 0);
            check_eq($sformatf("run%0d.add_b", k), int'(add_b), 1);
            step();
        end
        check_status("run.pc4", 4, 1, 1, 0);

        // Jump to 62 via a branch of 58, then step through the wrap.
        branch_valid = 1'b1; branch_offset = 6'd58;
        step();
        branch_valid = 1'b0;
        check_eq("br58.add_a", int'(add_a), 4);
        check_eq("br58.add_b", int'(add_b), 58);
        step();
        check_status("wrap.pc62", 62, 1, 1, 0);
        step(); step();
        check_status("wrap.pc63", 63, 1, 1, 0);
        step();
        check_status("wrap.update63", 63, 0, 1, 0);
        step();
        check_status("wrap.pc0", 0, 1, 1, 1);
        step();
        check_status("wrap.after", 0, 0, 1, 0);
        step();
        check_status("wrap.pc1", 1, 1, 1, 0);

        // Reach 10 with a branch of 9.
        branch_valid = 1'b1; branch_offset = 6'd9;
        step(); step();
        check_eq("br9.pc", int'(pc_out), 10);

        // Branch without handshake has no effect on the held operands.
        pc_ready = 1'b0; branch_offset = 6'd20;
        step();
        check_status("br20.stall", 10, 1, 1, 0);
        check_eq("br20.stall.add_b", int'(add_b), 9);
        pc_ready = 1'b1;
        step();
        pc_ready = 1'b0; branch_valid = 1'b0;
        check_eq("br20.add_a", int'(add_a), 10);
        check_eq("br20.add_b", int'(add_b), 20);
        step();
        check_status("br20.pc30", 30, 1, 1, 0);

        // Branch on a non-handshake cycle, then a plain step: 30 -> 31.
        branch_valid = 1'b1; branch_offset = 6'd5;
        step();
        branch_valid = 1'b0; pc_ready = 1'b1;
        step();
        check_eq("nobr.add_b", int'(add_b), 1);
        pc_ready = 1'b0;
        step();
        check_status("nobr.pc31", 31, 1, 1, 0);

        // Hold ready low for 5 cycles: everything stays put.
        for (int k = 0; k < 5; k++) begin
            step();
            check_status($sformatf("stall%0d", k), 31, 1, 1, 0);
            check_eq($sformatf("stall%0d.add_a", k), int'(add_a), 30);
            check_eq($sformatf("stall%0d.add_b", k), int'(add_b), 1);
        end
        pc_ready = 1'b1;
        step();
        pc_ready = 1'b0;
        step();
        check_status("stall.pc32", 32, 1, 1, 0);

        // halt without handshake -> IDLE, PC unchanged.
        halt = 1'b1;
        step();
        check_status("halt.nohs", 32, 0, 0, 0);
        // start and halt together in IDLE -> stays IDLE.
        step();
        check_status("halt.startidle", 32, 0, 0, 0);
        halt = 1'b0;
        step();
        check_status("resume", 32, 1, 1, 0);

        // halt with handshake: finish the update, then IDLE even though
        // halt has dropped and start is still high.
        halt = 1'b1; pc_ready = 1'b1;
        step();
        halt = 1'b0;
        check_status("halths.update", 32, 0, 1, 0);
        step();
        check_status("halths.idle", 33, 0, 0, 0);
        step();
        check_status("halths.restart", 33, 1, 1, 0);

        // Reset in the middle of UPDATE.
        step();
        check_status("rstupd.update", 33, 0, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_status("rstupd", 0, 0, 0, 0);
        check_eq("rstupd.add_a", int'(add_a), 0);
        check_eq("rstupd.add_b", int'(add_b), 0);
        step();
        check_status("rstupd.issue0", 0, 1, 1, 0);
        step(); step();
        check_status("rstupd.pc1", 1, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
